// File: rtl/cmd_seq_pkg.sv
// cmd_seq_pkg: shared types and constants for the command sequencer.
package cmd_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_SENT,
        WAIT_RESP,
        CHECK,
        ERR
    } state_e;

    typedef enum logic [1:0] {
        EC_NONE = 2'b00,
        EC_RESP = 2'b01,
        EC_TMO  = 2'b10,
        EC_OVF  = 2'b11
    } err_code_e;

    localparam int unsigned CMD_W       = 16;
    localparam logic [7:0]  ACK_DEFAULT = 8'hA5;

    localparam logic [3:0] OP_CAL  = 4'h2;
    localparam logic [3:0] OP_MOVE = 4'h4;
    localparam logic [3:0] OP_TOUR = 4'h6;

    function automatic logic [3:0] opcode_of(input logic [CMD_W-1:0] c);
        return c[15:12];
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: DEPTH x WIDTH queue with wrap-around pointers (extra MSB)
// and a single-cycle flush.
module cmd_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            rptr_d = wptr_q;
        end else begin
            if (do_push) wptr_d = wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: issues queued commands over a link, checks ACK, times out.
// Define CMD_SEQ_RETRY_EN to re-issue a failed command once before ERR.
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 80_000_000,
    parameter logic [7:0]  ACK     = ACK_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [15:0] wr_cmd,
    input  logic        start,
    input  logic        abort,
    output logic [15:0] cmd,
    output logic        send_cmd,
    input  logic        cmd_sent,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        full,
    output logic        empty,
    output logic [4:0]  cmds_done
);
    localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    state_e      state_q, state_d;
    err_code_e   code_q, code_d, fail_code;
    logic [15:0] cmd_q, cmd_d, head;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]  cdone_q, cdone_d;
    logic [7:0]  resp_q, resp_d;
    logic        send_q, send_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        rdy_q;
    logic        push, pop, flush, issue, fail;
    logic        rdy_edge, tmo;
`ifdef CMD_SEQ_RETRY_EN
    logic        retry_q, retry_d;
`endif

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (wr_cmd),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign push     = wr_en && !abort;
    assign rdy_edge = resp_rdy && !rdy_q;
    assign tmo      = (cnt_q >= TMO_LAST);

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        send_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        code_d    = code_q;
        cnt_d     = cnt_q;
        cdone_d   = cdone_q;
        resp_d    = resp_q;
        pop       = 1'b0;
        flush     = 1'b0;
        issue     = 1'b0;
        fail      = 1'b0;
        fail_code = EC_NONE;
`ifdef CMD_SEQ_RETRY_EN
        retry_d   = retry_q;
`endif

        unique case (state_q)
            IDLE, ERR: begin
                if (start) begin
                    err_d   = 1'b0;
                    code_d  = EC_NONE;
                    cdone_d = '0;
                    if (empty) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: issue = 1'b1;
            WAIT_SENT: begin
                cnt_d = cnt_q + CW'(1);
                if (tmo) begin
                    fail      = 1'b1;
                    fail_code = EC_TMO;
                end else if (cmd_sent) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                cnt_d = cnt_q + CW'(1);
                if (rdy_edge) begin
                    resp_d  = resp;
                    state_d = CHECK;
                end else if (tmo) begin
                    fail      = 1'b1;
                    fail_code = EC_TMO;
                end
            end
            CHECK: begin
                if (resp_q == ACK) begin
                    if (cdone_q != 5'd31) cdone_d = cdone_q + 5'd1;
                    if (empty) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        issue = 1'b1;
                    end
                end else begin
                    fail      = 1'b1;
                    fail_code = EC_RESP;
                end
            end
            default: state_d = IDLE;
        endcase

        // Back-to-back issue straight from CHECK keeps a 2-cycle turnaround.
        if (issue) begin
            pop     = 1'b1;
            cmd_d   = head;
            send_d  = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_SENT;
        end

`ifdef CMD_SEQ_RETRY_EN
        if (issue) retry_d = 1'b0;
        if (fail && !retry_q) begin
            retry_d = 1'b1;
            send_d  = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_SENT;
        end else if (fail) begin
            state_d = ERR;
            err_d   = 1'b1;
            code_d  = fail_code;
        end
`else
        if (fail) begin
            state_d = ERR;
            err_d   = 1'b1;
            code_d  = fail_code;
        end
`endif

        if (wr_en && full) begin
            err_d  = 1'b1;
            code_d = EC_OVF;
        end

        if (abort) begin
            state_d = IDLE;
            cmd_d   = cmd_q;
            send_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = err_q;
            code_d  = code_q;
            cdone_d = cdone_q;
            cnt_d   = '0;
            pop     = 1'b0;
            flush   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            send_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= EC_NONE;
            cnt_q   <= '0;
            cdone_q <= '0;
            resp_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            send_q  <= send_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            cdone_q <= cdone_d;
            resp_q  <= resp_d;
            rdy_q   <= resp_rdy;
        end
    end

`ifdef CMD_SEQ_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retry_q <= 1'b0;
        else        retry_q <= retry_d;
    end
`endif

    assign cmd       = cmd_q;
    assign send_cmd  = send_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = code_q;
    assign cmds_done = cdone_q;
    assign busy      = (state_q == ISSUE) || (state_q == WAIT_SENT) ||
                       (state_q == WAIT_RESP) || (state_q == CHECK);

endmodule
